// File: rtl/imm_ext_pkg.sv
// Immediate-extension shared types: mode encodings, default widths, stage states.
// Reused by the decoder, the NPC logic and imm_ext_stage.
package imm_ext_pkg;

  localparam int IMM_IN_W_DEF  = 16;
  localparam int IMM_OUT_W_DEF = 32;

  typedef enum logic [1:0] {
    IMM_ZERO   = 2'd0,
    IMM_SIGN   = 2'd1,
    IMM_UPPER  = 2'd2,
    IMM_BRANCH = 2'd3
  } imm_mode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } imm_state_e;

endpackage

// File: rtl/imm_ext_if.sv
// Handshake bundle between ID and the immediate stage, and on to EX.
// slave: the stage itself; master: the driver/consumer side.
interface imm_ext_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm_in;
  logic [1:0]       mode;
  logic [OUT_W-1:0] pc4_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] imm_out;
  logic [OUT_W-1:0] tgt_out;

  modport slave (
    input  in_valid, imm_in, mode, pc4_in,
    input  flush, out_ready,
    output in_ready, out_valid,
    output imm_out, tgt_out
  );

  modport master (
    output in_valid, imm_in, mode, pc4_in,
    output flush, out_ready,
    input  in_ready, out_valid,
    input  imm_out, tgt_out
  );

endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: raw field + mode -> OUT_W value.
// BRANCH is the sign-extended field shifted left 2, truncated.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W_DEF,
  parameter int OUT_W = IMM_OUT_W_DEF
) (
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  localparam int PAD = OUT_W - IN_W;

  imm_mode_e        m;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign m    = imm_mode_e'(mode);
  assign zext = {{PAD{1'b0}}, imm_in};
  assign sext = {{PAD{imm_in[IN_W-1]}}, imm_in};

  // Select the extension flavour for the current mode.
  always_comb begin
    ext = zext;
    unique case (m)
      IMM_ZERO:   ext = zext;
      IMM_SIGN:   ext = sext;
      IMM_UPPER:  ext = {imm_in, {PAD{1'b0}}};
      IMM_BRANCH: ext = sext << 2;
      default:    ext = zext;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// One-deep registered immediate stage with valid/ready handshake and flush.
// Optional branch target adder enabled by macro IMM_EXT_BRANCH_EN.
module imm_ext_stage
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W_DEF,
  parameter int OUT_W = IMM_OUT_W_DEF
) (
  input logic     clk,
  input logic     reset,
  imm_ext_if.slave bus
);

  imm_state_e       state_q, state_d;
  logic [OUT_W-1:0] imm_q, imm_d;
  logic [OUT_W-1:0] ext;
  logic             in_ready;
  logic             accept;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm_in (bus.imm_in),
    .mode   (bus.mode),
    .ext    (ext)
  );

`ifdef IMM_EXT_BRANCH_EN
  logic [OUT_W-1:0] tgt_q, tgt_d;
  logic [OUT_W-1:0] tgt_sum;

  assign tgt_sum = (bus.mode == IMM_BRANCH) ?
                   bus.pc4_in + ext : '0;
`endif

  // Handshake: next state, ready and result loading; flush wins.
  always_comb begin
    state_d  = state_q;
    imm_d    = imm_q;
`ifdef IMM_EXT_BRANCH_EN
    tgt_d    = tgt_q;
`endif
    in_ready = !bus.flush &&
               ((state_q == EMPTY) || bus.out_ready);
    accept   = bus.in_valid && in_ready;
    if (bus.flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FULL;
      imm_d   = ext;
`ifdef IMM_EXT_BRANCH_EN
      tgt_d   = tgt_sum;
`endif
    end else if (bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      imm_q   <= '0;
`ifdef IMM_EXT_BRANCH_EN
      tgt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
`ifdef IMM_EXT_BRANCH_EN
      tgt_q   <= tgt_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.imm_out   = imm_q;
`ifdef IMM_EXT_BRANCH_EN
  assign bus.tgt_out   = tgt_q;
`else
  assign bus.tgt_out   = '0;
`endif

endmodule

// File: doc/imm_ext_stage.md
IMM_EXT_STAGE -- requirements
Module: imm_ext_stage

Interface
REQ-001 Parameter IN_W, default 16, immediate input width.
REQ-002 Parameter OUT_W, default 32, extended output width; legal only when OUT_W >= IN_W+2.
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  immediate and mode presented this cycle.
REQ-006 in_ready  output  1  stage can accept; equals (!out_valid || out_ready), combinational.
REQ-007 imm_in  input  IN_W  raw immediate field.
REQ-008 mode  input  2  0 ZERO, 1 SIGN, 2 UPPER, 3 BRANCH.
REQ-009 pc4_in  input  OUT_W  PC+4 of owning instruction (used only with IMM_EXT_BRANCH_EN).
REQ-010 flush  input  1  kill held result (branch mispredict / exception).
REQ-011 out_valid  output  1  imm_out/tgt_out hold a valid result.
REQ-012 out_ready  input  1  downstream (EX) consumes result this cycle.
REQ-013 imm_out  output  OUT_W  registered extended immediate.
REQ-014 tgt_out  output  OUT_W  registered branch target (tied 0 without IMM_EXT_BRANCH_EN).

Function
REQ-015 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 Latency exactly 1 cycle: accepted data appears on imm_out with out_valid the next cycle.
REQ-017 ZERO: imm_out = IN_W input zero-extended to OUT_W.
REQ-018 SIGN: imm_out = input replicated MSB to OUT_W.
REQ-019 UPPER: imm_out = imm_in shifted left by (OUT_W-IN_W), low bits zero.
REQ-020 BRANCH: imm_out = sign-extended imm_in shifted left 2, truncated to OUT_W.
REQ-021 Held result shall not change while out_valid && !out_ready (stall hold).
REQ-022 Accept and drain in the same cycle: new result loaded, out_valid stays 1 (full throughput).
REQ-023 Drain without accept: out_valid -> 0, imm_out/tgt_out keep last value.
REQ-024 flush asserted: out_valid -> 0 next cycle, in_ready forced 0 that cycle, any in_valid that cycle discarded; flush beats accept and stall.
REQ-025 Two states only, EMPTY (out_valid=0) and FULL (out_valid=1); no other state.

Reset
REQ-026 reset asserted at any time, including mid-stall: out_valid=0, imm_out=0, tgt_out=0 immediately, without waiting for clk.
REQ-027 First accept possible on first rising clk after reset deasserts.

Configuration
REQ-028 Macro IMM_EXT_BRANCH_EN defined: tgt_out = pc4_in + BRANCH offset (mod 2^OUT_W), registered alongside imm_out, meaningful for mode 3, 0 for modes 0-2.
REQ-029 Macro undefined: no adder, pc4_in ignored, tgt_out constant 0, mode 3 still produces BRANCH offset on imm_out.

Structure
REQ-030 Shared package/header holds mode encodings (IMM_ZERO, IMM_SIGN, IMM_UPPER, IMM_BRANCH) and default widths, reused by decoder and NPC.
REQ-031 One combinational sub-module imm_ext_core (imm_in, mode -> extended value); imm_ext_stage adds the handshake register and optional target adder.

Verification
REQ-032 IN_W=16, OUT_W=32: imm_in=0x8001 per mode -> ZERO 0x00008001, SIGN 0xFFFF8001, UPPER 0x80010000, BRANCH 0xFFFE0004, each one cycle after accept.
REQ-033 Stall: accept 0x1234 SIGN, out_ready=0 for 3 cycles while in_valid=1 with 0x5678 -> imm_out holds 0x00001234, in_ready=0; release -> 0x00005678 next cycle.
REQ-034 Back-to-back in_valid and out_ready=1 for 8 cycles -> 8 results, no bubbles, out_valid continuously 1.
REQ-035 flush with out_valid=1 and in_valid=1 same cycle -> out_valid=0 next cycle, input dropped.
REQ-036 IMM_EXT_BRANCH_EN, pc4_in=0x00400010, imm_in=0xFFFF BRANCH -> tgt_out=0x0040000C; reset pulse mid-stall -> out_valid, imm_out, tgt_out 0 asynchronously.
